demux_stream_router: RTL

- Packet-locked 1-to-N stream demultiplexer controller with valid/ready handshakes on both sides.
- Steers input beats to one of N_OUT output channels.
- Destination is sampled on the first beat of each packet and held until the beat with s_last.
- Each output channel has a single-entry output register, so a stalled output never blocks traffic already routed elsewhere. Sits between a single producer and N_OUT downstream consumers.

---
 rtl/demux_stream_router.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/demux_stream_router.sv
// Packet-locked 1-to-N_OUT stream demultiplexer with one output register per channel.
// Optional discarded-packet counter enabled by defining DEMUX_DROP_CNT_EN.
module demux_stream_router #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_OUT  = 2,
   parameter int unsigned SEL_W  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       s_data,
   input  logic [SEL_W-1:0]        s_sel,
   input  logic                    s_last,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [N_OUT*DATA_W-1:0] m_data,
   output logic [N_OUT-1:0]        m_last,
   output logic [N_OUT-1:0]        m_valid,
   input  logic [N_OUT-1:0]        m_ready,
   output logic                    busy,
   output logic [SEL_W-1:0]        cur_sel
`ifdef DEMUX_DROP_CNT_EN
   ,
   output logic [7:0]              drop_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

   state_t                    state_q, state_d;
   logic [SEL_W-1:0]          cur_sel_q, cur_sel_d;
   logic                      busy_q, busy_d;
   logic [N_OUT*DATA_W-1:0]   m_data_q, m_data_d;
   logic [N_OUT-1:0]          m_last_q, m_last_d;
   logic [N_OUT-1:0]          m_valid_q, m_valid_d;

   logic [SEL_W-1:0]          target;
   logic                      sel_ok;
   logic [N_OUT-1:0]          hit;
   logic                      accept;
   logic                      drop_done;

`ifdef DEMUX_DROP_CNT_EN
   logic [7:0]                drop_cnt_q, drop_cnt_d;
`endif

   always_comb begin
      target = (state_q == IDLE) ? s_sel : cur_sel_q;
      sel_ok = (32'(s_sel) < N_OUT);

      // One-hot channel decode; empty in DROP or for an out-of-range destination
      hit = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         if ((state_q == ROUTE || (state_q == IDLE && sel_ok)) && target == SEL_W'(k))
            hit[k] = 1'b1;
      end

      s_ready = ~|(hit & m_valid_q & ~m_ready);
      accept  = s_valid && s_ready;

      m_data_d = m_data_q;
      m_last_d = m_last_q;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         m_valid_d[k] = m_valid_q[k] & ~m_ready[k];
         if (accept && hit[k]) begin
            m_valid_d[k]                 = 1'b1;
            m_data_d[k*DATA_W +: DATA_W] = s_data;
            m_last_d[k]                  = s_last;
         end
      end

      state_d   = state_q;
      cur_sel_d = cur_sel_q;
      drop_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sel_ok) begin
                  cur_sel_d = s_sel;
                  if (!s_last) state_d = ROUTE;
               end else if (!s_last) begin
                  state_d = DROP;
               end else begin
                  drop_done = 1'b1;
               end
            end
         end
         ROUTE: begin
            if (accept && s_last) state_d = IDLE;
         end
         DROP: begin
            if (accept && s_last) begin
               state_d   = IDLE;
               drop_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);

`ifdef DEMUX_DROP_CNT_EN
      drop_cnt_d = drop_cnt_q;
      if (drop_done && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_sel_q  <= '0;
         busy_q     <= 1'b0;
         m_data_q   <= '0;
         m_last_q   <= '0;
         m_valid_q  <= '0;
`ifdef DEMUX_DROP_CNT_EN
         drop_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cur_sel_q  <= cur_sel_d;
         busy_q     <= busy_d;
         m_data_q   <= m_data_d;
         m_last_q   <= m_last_d;
         m_valid_q  <= m_valid_d;
`ifdef DEMUX_DROP_CNT_EN
         drop_cnt_q <= drop_cnt_d;
`endif
      end
   end

   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign m_valid = m_valid_q;
   assign busy    = busy_q;
   assign cur_sel = cur_sel_q;
`ifdef DEMUX_DROP_CNT_EN
   assign drop_cnt = drop_cnt_q;
`endif

endmodule
